// File: rtl/av2_tile_decoder_real.sv
// Simplified AV2-style tile reconstruction: dequantizes 16 coefficient bytes per word,
// adds an intra (flat 128) or inter (reference sample) predictor, clamps and writes out.
module av2_tile_decoder_real #(
  parameter int MAX_WIDTH   = 64,
  parameter int MAX_HEIGHT  = 64,
  parameter int PIXEL_WIDTH = 10,
  parameter int MAX_SB_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [15:0]            frame_width,
  input  logic [15:0]            frame_height,
  input  logic [7:0]             qindex,
  input  logic [1:0]             frame_type,
  input  logic [127:0]           tile_data,
  input  logic                   tile_valid,
  output logic                   tile_ready,
  output logic [31:0]            ref_read_addr,
  output logic                   ref_read_en,
  input  logic [PIXEL_WIDTH-1:0] ref_pixel_data,
  output logic [127:0]           recon_data,
  output logic [31:0]            recon_addr,
  output logic                   recon_wr_en,
  output logic                   tile_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] MAX_W = 16'(MAX_WIDTH);
  localparam logic [15:0] MAX_H = 16'(MAX_HEIGHT);

  state_t         state_q, state_d;
  logic [31:0]    k_q, k_d;
  logic [31:0]    n_q, n_d;
  logic [5:0]     qstep_q, qstep_d;
  logic           inter_q, inter_d;
  logic [127:0]   pix_q, pix_d;

  logic [15:0]    w_eff, h_eff;
  logic [31:0]    n_start;
  logic [7:0]     pred;
  logic [127:0]   pix_calc;
  logic [31:0]    k_next;
  logic           unused_bits;

  // Residual is at most |-128 * 32| >> 4 = 256, so 16-bit signed math cannot overflow before the clamp.
  function automatic logic [7:0] recon_pixel(input logic [7:0] coef,
                                             input logic [5:0] qstep,
                                             input logic [7:0] pred_px);
    logic signed [15:0] c;
    logic signed [15:0] q;
    logic signed [15:0] r;
    logic signed [15:0] s;
    c = $signed({{8{coef[7]}}, coef});
    q = $signed({10'd0, qstep});
    r = (c * q) >>> 4;
    s = $signed({8'd0, pred_px}) + r;
    if (s < 16'sd0) begin
      return 8'd0;
    end else if (s > 16'sd255) begin
      return 8'd255;
    end
    return s[7:0];
  endfunction

  always_comb begin
    w_eff    = (frame_width  > MAX_W) ? MAX_W : frame_width;
    h_eff    = (frame_height > MAX_H) ? MAX_H : frame_height;
    n_start  = (32'(w_eff) * 32'(h_eff) * 32'd3) >> 5;
    pred     = inter_q ? ref_pixel_data[PIXEL_WIDTH-1 -: 8] : 8'd128;
    k_next   = k_q + 32'd1;
    pix_calc = '0;
    for (int i = 0; i < 16; i++) begin
      pix_calc[8*i +: 8] = recon_pixel(tile_data[8*i +: 8], qstep_q, pred);
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    qstep_d = qstep_q;
    inter_d = inter_q;
    pix_d   = pix_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = '0;
          n_d     = n_start;
          qstep_d = {1'b0, qindex[7:3]} + 6'd1;
          inter_d = (frame_type != 2'd0);
          state_d = (n_start == 32'd0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (tile_valid) begin
          pix_d   = pix_calc;
          state_d = WRITE;
        end
      end
      WRITE: begin
        k_d     = k_next;
        state_d = (k_next < n_q) ? FETCH : DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      n_q     <= '0;
      qstep_q <= 6'd1;
      inter_q <= 1'b0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      qstep_q <= qstep_d;
      inter_q <= inter_d;
      pix_q   <= pix_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset clears them at once.
  always_comb begin
    tile_ready    = (state_q == FETCH);
    ref_read_en   = (state_q == FETCH) && inter_q;
    ref_read_addr = ref_read_en ? {k_q[27:0], 4'd0} : 32'd0;
    recon_wr_en   = (state_q == WRITE);
    recon_addr    = k_q;
    recon_data    = pix_q;
    tile_done     = (state_q == DONE);
  end

  assign unused_bits = ^{qindex[2:0], ref_pixel_data, 32'(MAX_SB_SIZE)};

endmodule

// File: tb/tb_av2_tile_decoder_real.sv
// Randomized self-checking bench: a per-cycle behavioural model plus literal pins
// on the worked examples (flat 0x10 frame, clamp cases, inter predictor, reset, N=0).
module tb_av2_tile_decoder_real;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  frame_width = '0;
  logic [15:0]  frame_height = '0;
  logic [7:0]   qindex = '0;
  logic [1:0]   frame_type = '0;
  logic [127:0] tile_data = '0;
  logic         tile_valid = 1'b0;
  logic         tile_ready;
  logic [31:0]  ref_read_addr;
  logic         ref_read_en;
  logic [9:0]   ref_pixel_data = '0;
  logic [127:0] recon_data;
  logic [31:0]  recon_addr;
  logic         recon_wr_en;
  logic         tile_done;

  int checks = 0;
  int errors = 0;

  // model state
  bit           m_fetch = 0, m_write = 0, m_done = 0, m_inter = 0;
  int           m_k = 0, m_n = 0, m_qs = 1;
  logic [127:0] m_pix = '0;

  // per-run bookkeeping
  int           wr_count = 0, done_count = 0, ref_en_count = 0;
  int           first_addr = -1, last_addr = -1;
  logic [127:0] last_data = '0;
  int           img_sel = 0;
  logic [127:0] img_a [384];
  logic [127:0] img_b [384];

  av2_tile_decoder_real dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .frame_width(frame_width), .frame_height(frame_height),
    .qindex(qindex), .frame_type(frame_type),
    .tile_data(tile_data), .tile_valid(tile_valid), .tile_ready(tile_ready),
    .ref_read_addr(ref_read_addr), .ref_read_en(ref_read_en), .ref_pixel_data(ref_pixel_data),
    .recon_data(recon_data), .recon_addr(recon_addr), .recon_wr_en(recon_wr_en),
    .tile_done(tile_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reconstruct one word from the arithmetic rules: floor(b*qstep/16) added to pred, clamped.
  function automatic logic [127:0] model_word(input logic [127:0] d, input int qs, input int p);
    logic [127:0] res;
    byte          sb;
    int           b, v;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      sb = d[8*i +: 8];
      b  = sb;
      v  = p + ((b * qs) >>> 4);
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      res[8*i +: 8] = 8'(v);
    end
    return res;
  endfunction

  function automatic logic [127:0] word_pattern(input int k, input int salt);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'((k * 37 + i * 11 + salt * 5) & 255);
    return r;
  endfunction

  // Behavioural model advancing one cycle per clock edge.
  always @(posedge clk or negedge rst_n) begin
    int w, h;
    if (!rst_n) begin
      m_fetch = 0; m_write = 0; m_done = 0; m_k = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_write) begin
      m_write = 0;
      m_k = m_k + 1;
      if (m_k < m_n) m_fetch = 1; else m_done = 1;
    end else if (m_fetch) begin
      if (tile_valid) begin
        m_pix   = model_word(tile_data, m_qs, m_inter ? int'(ref_pixel_data) / 4 : 128);
        m_fetch = 0;
        m_write = 1;
      end
    end else if (start) begin
      w = (frame_width > 64) ? 64 : int'(frame_width);
      h = (frame_height > 64) ? 64 : int'(frame_height);
      m_n = (w * h * 3 / 2) / 16;
      m_qs = int'(qindex) / 8 + 1;
      m_inter = (frame_type != 0);
      m_k = 0;
      if (m_n == 0) m_done = 1; else m_fetch = 1;
    end
  end

  // Compare process: DUT against model every cycle, away from the active edge.
  always @(negedge clk) begin
    checkOutput("tile_ready", tile_ready, m_fetch);
    checkOutput("recon_wr_en", recon_wr_en, m_write);
    checkOutput("tile_done", tile_done, m_done);
    checkOutput("ref_read_en", ref_read_en, m_fetch && m_inter);
    if (m_fetch && m_inter) checkOutput("ref_read_addr", ref_read_addr, 32'(m_k * 16));
    if (m_write) begin
      checkOutput("recon_addr", recon_addr, 32'(m_k));
      checkOutput("recon_data", recon_data, m_pix);
    end
    if (recon_wr_en) begin
      wr_count++;
      if (first_addr < 0) first_addr = int'(recon_addr);
      last_addr = int'(recon_addr);
      last_data = recon_data;
      if (recon_addr < 384) begin
        if (img_sel == 1) img_a[recon_addr] = recon_data;
        if (img_sel == 2) img_b[recon_addr] = recon_data;
      end
    end
    if (tile_done) done_count++;
    if (ref_read_en) ref_en_count++;
  end

  // mode: 0 constant pat, 1 per-word pattern, 2 random each cycle; refv < 0 means random ref.
  task automatic applyStimulus(input logic [15:0] fw, input logic [15:0] fh, input logic [7:0] q,
                               input logic [1:0] ft, input int valid_pct, input int mode,
                               input logic [127:0] pat, input int refv, input int stop_writes,
                               input bit busy_start);
    int cyc;
    wr_count = 0; done_count = 0; ref_en_count = 0; first_addr = -1; last_addr = -1;
    frame_width = fw; frame_height = fh; qindex = q; frame_type = ft;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    cyc = 0;
    while (done_count == 0 && cyc < 5000) begin
      tile_valid = ($urandom_range(99) < valid_pct);
      case (mode)
        0:       tile_data = pat;
        1:       tile_data = word_pattern(m_k, 3);
        default: tile_data = {$urandom, $urandom, $urandom, $urandom};
      endcase
      ref_pixel_data = (refv < 0) ? 10'($urandom) : 10'(refv);
      if (busy_start && cyc == 40) begin
        start = 1'b1;
        frame_width = 16'd16;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #2;
      cyc++;
      if (stop_writes > 0 && wr_count >= stop_writes) break;
    end
    start = 1'b0;
    if (stop_writes == 0) begin
      checkOutput("run_finished", (done_count != 0), 1'b1);
      tile_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int mism;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tile_ready", tile_ready, 0);
    checkOutput("rst_wr_en", recon_wr_en, 0);
    checkOutput("rst_tile_done", tile_done, 0);
    checkOutput("rst_ref_en", ref_read_en, 0);
    checkOutput("rst_recon_data", recon_data, 0);
    checkOutput("rst_recon_addr", recon_addr, 0);
    checkOutput("rst_ref_addr", ref_read_addr, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // flat 64x64 intra frame, bytes 0x10 at qindex 32
    applyStimulus(64, 64, 32, 0, 100, 0, {16{8'h10}}, 0, 0, 0);
    checkOutput("flat_writes", wr_count, 384);
    checkOutput("flat_done", done_count, 1);
    checkOutput("flat_data", last_data, {16{8'h85}});
    checkOutput("flat_first_addr", first_addr, 0);
    checkOutput("flat_last_addr", last_addr, 383);
    checkOutput("intra_ref_en", ref_en_count, 0);

    // continuous vs randomly stalled valid must reconstruct the same image
    img_sel = 1;
    applyStimulus(64, 64, 77, 0, 100, 1, '0, 0, 0, 0);
    img_sel = 2;
    applyStimulus(64, 64, 77, 0, 40, 1, '0, 0, 0, 0);
    img_sel = 0;
    checkOutput("stall_writes", wr_count, 384);
    mism = 0;
    for (int i = 0; i < 384; i++) if (img_a[i] !== img_b[i]) mism++;
    checkOutput("stall_image_match", mism, 0);

    // negative / positive residuals at qindex 32
    applyStimulus(16, 16, 32, 0, 100, 0, {8{8'h7F, 8'hF0}}, 0, 0, 0);
    checkOutput("small_writes", wr_count, 24);
    checkOutput("neg_residual", last_data[7:0], 8'h7B);
    checkOutput("pos_residual", last_data[15:8], 8'hA7);

    // clamping at qindex 255
    applyStimulus(16, 16, 255, 0, 100, 0, {8{8'h80, 8'h7F}}, 0, 0, 0);
    checkOutput("clamp_high", last_data[7:0], 8'hFF);
    checkOutput("clamp_low", last_data[15:8], 8'h00);

    // inter predictor from reference sample 512
    applyStimulus(16, 16, 32, 1, 70, 0, '0, 512, 0, 0);
    checkOutput("inter_data", last_data, {16{8'h80}});
    checkOutput("inter_ref_en_seen", (ref_en_count > 0), 1'b1);

    // reset mid-decode after 10 writes
    applyStimulus(64, 64, 32, 1, 100, 2, '0, -1, 10, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_tile_ready", tile_ready, 0);
    checkOutput("abort_wr_en", recon_wr_en, 0);
    checkOutput("abort_ref_en", ref_read_en, 0);
    checkOutput("abort_recon_data", recon_data, 0);
    checkOutput("abort_recon_addr", recon_addr, 0);
    checkOutput("abort_ref_addr", ref_read_addr, 0);
    tile_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    tile_valid = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    tile_valid = 1'b0;
    checkOutput("abort_no_more_writes", wr_count, 10);
    applyStimulus(64, 64, 32, 0, 100, 0, {16{8'h10}}, 0, 0, 0);
    checkOutput("after_abort_writes", wr_count, 384);
    checkOutput("after_abort_first_addr", first_addr, 0);

    // zero-width frame
    applyStimulus(0, 64, 32, 0, 100, 0, {16{8'h10}}, 0, 0, 0);
    checkOutput("zero_writes", wr_count, 0);
    checkOutput("zero_done", done_count, 1);

    // start while busy is ignored
    applyStimulus(64, 64, 32, 0, 100, 0, {16{8'h10}}, 0, 0, 1);
    checkOutput("busy_start_writes", wr_count, 384);
    checkOutput("busy_start_done", done_count, 1);

    // random frames, including oversize dimensions that clamp to 64
    for (int r = 0; r < 5; r++) begin
      applyStimulus(16'(16 * $urandom_range(1, 5)), 16'(16 * $urandom_range(1, 5)),
                    8'($urandom), 2'($urandom), int'($urandom_range(30, 100)), 2, '0, -1, 0, 0);
      checkOutput("rand_done", done_count, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/av2_tile_decoder_real.md
AV2_TILE_DECODER_REAL -- requirements
Module: av2_tile_decoder_real

Interface
REQ-001 SHALL have parameter MAX_WIDTH, default 64: largest supported luma width in pixels.
REQ-002 SHALL have parameter MAX_HEIGHT, default 64: largest supported luma height in pixels.
REQ-003 SHALL have parameter PIXEL_WIDTH, default 10: width of reference pixel samples.
REQ-004 SHALL have parameter MAX_SB_SIZE, default 16: superblock size; output word width in pixels equals 16 regardless.
REQ-005 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1 bit: one-cycle decode request.
REQ-008 SHALL have ports frame_width and frame_height, input, 16 bits each: luma dimensions, sampled on accepted start.
REQ-009 SHALL have port qindex, input, 8 bits: quantizer index, sampled on accepted start.
REQ-010 SHALL have port frame_type, input, 2 bits: 0 = intra, other = inter; sampled on accepted start.
REQ-011 SHALL have ports tile_data (input, 128 bits), tile_valid (input, 1 bit) and tile_ready (output, 1 bit): coefficient stream; byte i = tile_data[8i+7:8i].
REQ-012 SHALL have ports ref_read_addr (output, 32 bits), ref_read_en (output, 1 bit) and ref_pixel_data (input, PIXEL_WIDTH bits): reference read; data is valid in the same cycle.
REQ-013 SHALL have ports recon_data (output, 128 bits), recon_addr (output, 32 bits), recon_wr_en (output, 1 bit) and tile_done (output, 1 bit).

Function
REQ-014 SHALL implement an FSM with states IDLE, FETCH, WRITE and DONE.
REQ-015 In IDLE, start=1 SHALL latch parameters, clear the word index k to 0 and enter FETCH; start in any other state SHALL be ignored.
REQ-016 Latched w and h SHALL be min(frame_width, MAX_WIDTH) and min(frame_height, MAX_HEIGHT).
REQ-017 Word count SHALL be N = (w*h*3/2)>>4 (4:2:0 data: Y, then Cb, then Cr, raster order); the bench uses w and h as multiples of 16.
REQ-018 If N = 0, the FSM SHALL go from IDLE directly to DONE.
REQ-019 tile_ready SHALL be 1 only in FETCH.
REQ-020 A word SHALL be accepted on a rising edge with tile_valid & tile_ready; the FSM then registers 16 pixels and enters WRITE.
REQ-021 In FETCH with frame_type != 0, ref_read_en SHALL be 1 and ref_read_addr SHALL be k*16.
REQ-022 In FETCH with frame_type != 0, the predictor pred SHALL be ref_pixel_data[PIXEL_WIDTH-1:PIXEL_WIDTH-8], captured at accept.
REQ-023 With frame_type = 0, pred SHALL be 128 and ref_read_en SHALL be 0.
REQ-024 Dequantization: qstep = qindex[7:3] + 1 (range 1..32); residual_i = (signed byte_i * qstep) >>> 4, arithmetic shift.
REQ-025 Output pixel_i = clamp(pred + residual_i, 0, 255), packed into recon_data[8i+7:8i].
REQ-026 Arithmetic SHALL use at least 14-bit signed width so that no overflow occurs before the clamp.
REQ-027 In WRITE, recon_wr_en SHALL be 1 for exactly one cycle, with recon_addr = k and recon_data holding the registered pixels.
REQ-028 After WRITE, k SHALL increment; the FSM returns to FETCH if k+1 < N, otherwise enters DONE.
REQ-029 Throughput SHALL be at most one word per 2 cycles; recon_wr_en SHALL assert exactly 1 cycle after accept.
REQ-030 DONE SHALL assert tile_done for one cycle and then return to IDLE.
REQ-031 A stalled tile_valid in FETCH SHALL hold the state and all outputs.
REQ-032 Words offered after N accepts SHALL be ignored, since tile_ready = 0.

Reset
REQ-033 On rst_n = 0, asynchronously and including mid-decode, the FSM SHALL go to IDLE with k = 0.
REQ-034 Reset values SHALL be: tile_ready, recon_wr_en, tile_done and ref_read_en = 0; recon_data, recon_addr and ref_read_addr = 0.
REQ-035 A partially decoded frame SHALL be abandoned on reset, with no further writes.

Verification
REQ-036 64x64, qindex=32, frame_type=0, all bytes 0x10, valid always 1 -> 384 writes, each pixel 0x85 (133), addr 0..383, then one tile_done pulse.
REQ-037 qindex=32, bytes 0xF0 and 0x7F -> pixels 0x7B (123) and 0xA7 (167); qindex=255, byte 0x7F -> 0xFF (clamped); byte 0x80 -> 0x00.
REQ-038 frame_type=1, ref_pixel_data=10'd512, bytes 0 -> ref_read_en=1 in FETCH with addr k*16 and all pixels 0x80; frame_type=0 -> ref_read_en never 1.
REQ-039 tile_valid toggled randomly -> the same 384 outputs as continuous valid; each write exactly 1 cycle after its accept.
REQ-040 rst_n pulsed low after 10 writes -> all outputs 0 immediately; a following start runs a full decode from addr 0.
REQ-041 frame_width=0, or start asserted while busy -> tile_done pulse with no writes, or the start is ignored (no restart), respectively.
